pwm_multi: RTL and testbench

- Parametrised N-channel PWM generator. All channels share one period counter and TOP value; each channel has its own compare value.
- Successor to the single-channel PWM block. Adds:
  - generic width and channel count
  - double-buffered (shadow) compare/TOP registers
  - centre-aligned (up/down) mode
  - enable control and a period-end strobe
- Sits on the same simple register-write bus as the single-channel block: d plus a select code.

---
 rtl/pwm_multi.sv | 206 ++++++++++++++++++++
 tb/tb_pwm_multi.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_multi.sv
// pwm_multi: N-channel PWM generator sharing one period counter and TOP value.
// Compare and TOP registers are double-buffered. Shadows move to the active
// copies on each period boundary, and on every cycle while the block is disabled.
// Edge-aligned and centre-aligned (up/down) counting are both supported.
// Optional build macro PWM_POLARITY_EN adds per-channel output polarity,
// loaded from ctrl bits d[N+1:2]. This option needs W >= N+2.
module pwm_multi #(
  parameter int unsigned W = 16,
  parameter int unsigned N = 4,
  localparam int unsigned CH_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            wr_en,
  input  logic [1:0]      wr_sel,
  input  logic [CH_W-1:0] wr_ch,
  input  logic [W-1:0]    d,
  output logic [W-1:0]    cnt,
  output logic [W-1:0]    top,
  output logic [N-1:0]    pwm_out,
  output logic            period_end
);

  localparam int unsigned SEL_W = 2;
  localparam logic [SEL_W-1:0] SEL_CTRL = 2'b00;
  localparam logic [SEL_W-1:0] SEL_CMP  = 2'b01;
  localparam logic [SEL_W-1:0] SEL_TOP  = 2'b10;
  localparam logic [SEL_W-1:0] SEL_CNT  = 2'b11;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

`ifdef PWM_POLARITY_EN
  // Polarity bits are taken from the ctrl word, so they must fit in d.
  generate
    if (W < N + 2) begin : g_pol_width_check
      $error("pwm_multi: PWM_POLARITY_EN requires W >= N+2");
    end
  endgenerate
`endif

  // Registered state
  logic [W-1:0] cnt_q,     cnt_d;
  dir_e         dir_q,     dir_d;
  logic         en_q,      en_d;
  logic         mode_q,    mode_d;
  logic [W-1:0] top_shd_q, top_shd_d;
  logic [W-1:0] top_act_q, top_act_d;
  logic [W-1:0] cmp_shd_q [N];
  logic [W-1:0] cmp_shd_d [N];
  logic [W-1:0] cmp_act_q [N];
  logic [W-1:0] cmp_act_d [N];
  logic         pe_q,      pe_d;
`ifdef PWM_POLARITY_EN
  logic [N-1:0] pol_q,     pol_d;
`endif

  // Combinational helpers
  logic         boundary;
  logic         transfer;
  logic         cnt_wr;

  assign cnt        = cnt_q;
  assign top        = top_act_q;
  assign period_end = pe_q;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      dir_q     <= DIR_UP;
      en_q      <= 1'b0;
      mode_q    <= 1'b0;
      top_shd_q <= '0;
      top_act_q <= '0;
      pe_q      <= 1'b0;
      for (int unsigned i = 0; i < N; i++) begin
        cmp_shd_q[i] <= '0;
        cmp_act_q[i] <= '0;
      end
`ifdef PWM_POLARITY_EN
      pol_q     <= '0;
`endif
    end else begin
      cnt_q     <= cnt_d;
      dir_q     <= dir_d;
      en_q      <= en_d;
      mode_q    <= mode_d;
      top_shd_q <= top_shd_d;
      top_act_q <= top_act_d;
      pe_q      <= pe_d;
      for (int unsigned i = 0; i < N; i++) begin
        cmp_shd_q[i] <= cmp_shd_d[i];
        cmp_act_q[i] <= cmp_act_d[i];
      end
`ifdef PWM_POLARITY_EN
      pol_q     <= pol_d;
`endif
    end
  end

  // Register-bus writes into ctrl and the shadow registers
  always_comb begin
    en_d      = en_q;
    mode_d    = mode_q;
    top_shd_d = top_shd_q;
    for (int unsigned i = 0; i < N; i++) begin
      cmp_shd_d[i] = cmp_shd_q[i];
    end
`ifdef PWM_POLARITY_EN
    pol_d     = pol_q;
`endif
    if (wr_en) begin
      case (wr_sel)
        SEL_CTRL: begin
          en_d   = d[0];
          mode_d = d[1];
`ifdef PWM_POLARITY_EN
          pol_d  = d[N+1:2];
`endif
        end
        SEL_CMP: begin
          // A channel index of N or more matches no channel, so the write is dropped.
          for (int unsigned i = 0; i < N; i++) begin
            if (wr_ch == CH_W'(i)) begin
              cmp_shd_d[i] = d;
            end
          end
        end
        SEL_TOP: top_shd_d = d;
        default: ;
      endcase
    end
  end

  // Counter next-state and boundary detection
  always_comb begin
    cnt_d    = cnt_q;
    dir_d    = dir_q;
    boundary = 1'b0;
    cnt_wr   = wr_en && (wr_sel == SEL_CNT);
    if (cnt_wr) begin
      // A direct load overrides counting and never produces a boundary.
      cnt_d = d;
      dir_d = DIR_UP;
    end else if (en_q) begin
      if (!mode_q) begin
        // Edge-aligned: 0..top, then wrap.
        if (cnt_q >= top_act_q) begin
          cnt_d    = '0;
          boundary = 1'b1;
        end else begin
          cnt_d = cnt_q + W'(1);
        end
      end else if (dir_q == DIR_UP) begin
        // Centre-aligned rising slope.
        if (cnt_q >= top_act_q) begin
          if (cnt_q <= W'(1)) begin
            // top of 0 or 1: the turn-around lands on 0, which starts a new period.
            cnt_d    = '0;
            boundary = 1'b1;
          end else begin
            cnt_d = cnt_q - W'(1);
            dir_d = DIR_DOWN;
          end
        end else begin
          cnt_d = cnt_q + W'(1);
        end
      end else begin
        // Centre-aligned falling slope; a count of 0 is treated like 1 so the counter never underflows.
        if (cnt_q <= W'(1)) begin
          cnt_d    = '0;
          dir_d    = DIR_UP;
          boundary = 1'b1;
        end else begin
          cnt_d = cnt_q - W'(1);
        end
      end
    end
  end

  // Shadow-to-active transfer and period strobe
  always_comb begin
    transfer  = !en_q || boundary;
    top_act_d = transfer ? top_shd_q : top_act_q;
    for (int unsigned i = 0; i < N; i++) begin
      cmp_act_d[i] = transfer ? cmp_shd_q[i] : cmp_act_q[i];
    end
    pe_d = boundary;
  end

  // PWM outputs, combinational from the registered counter and compares
  always_comb begin
    pwm_out = '0;
    for (int unsigned i = 0; i < N; i++) begin
`ifdef PWM_POLARITY_EN
      pwm_out[i] = (en_q && (cnt_q < cmp_act_q[i])) ^ pol_q[i];
`else
      pwm_out[i] = en_q && (cnt_q < cmp_act_q[i]);
`endif
    end
  end

endmodule

// File: tb/tb_pwm_multi.sv
// tb_pwm_multi: scoreboard bench for pwm_multi (W=16, N=4).
// Each scenario queues per-cycle stimulus together with the expected outputs.
// The expected outputs are popped and compared one cycle later, after the clock edge.
module tb_pwm_multi;

  logic        clk;
  logic        rst_n;
  logic        wr_en;
  logic [1:0]  wr_sel;
  logic [1:0]  wr_ch;
  logic [15:0] d;
  logic [15:0] cnt;
  logic [15:0] top;
  logic [3:0]  pwm_out;
  logic        period_end;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic        wr;
    logic [1:0]  sel;
    logic [1:0]  ch;
    logic [15:0] d;
  } stim_t;

  typedef struct {
    logic [15:0] cnt;
    logic [15:0] top;
    logic [3:0]  pwm;
    logic        pe;
  } exp_t;

  stim_t stim_q[$];
  exp_t  exp_q[$];

  pwm_multi #(.W(16), .N(4)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_sel(wr_sel), .wr_ch(wr_ch),
    .d(d), .cnt(cnt), .top(top), .pwm_out(pwm_out), .period_end(period_end)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Queue one cycle of stimulus and the outputs expected after that edge
  function automatic void add(input logic wr, input logic [1:0] sel, input logic [1:0] ch,
                              input logic [15:0] dv, input logic [15:0] ecnt,
                              input logic [15:0] etop, input logic [3:0] epwm, input logic epe);
    stim_t s;
    exp_t  e;
    s = '{wr, sel, ch, dv};
    e = '{ecnt, etop, epwm, epe};
    stim_q.push_back(s);
    exp_q.push_back(e);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] sel, input logic [1:0] ch, input logic [15:0] dv);
    wr_en = 1'b1; wr_sel = sel; wr_ch = ch; d = dv;
    step();
    wr_en = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) step();
    n_cmp++;
    if ({cnt, top, pwm_out, period_end} !== 37'd0) begin
      n_bad++;
      $display("FAIL reset: cnt=%0d top=%0d pwm=%b pe=%b, want all 0", cnt, top, pwm_out, period_end);
    end
    rst_n = 1'b1;
    step();
  endtask

  // TOP=4, cmp0=2, cmp1=0, cmp2=7, cmp3=0 preloaded while disabled, then enabled in edge mode
  task automatic test_preload_edge();
    stim_t s;
    exp_t  e;
    int    row;
    logic [15:0] c;
    wr(2'b10, 2'd0, 16'd4);
    wr(2'b01, 2'd0, 16'd2);
    wr(2'b01, 2'd1, 16'd0);
    wr(2'b01, 2'd2, 16'd7);
    wr(2'b01, 2'd3, 16'd0);
    step();
    add(1'b1, 2'b00, 2'd0, 16'h0001, 16'd0, 16'd4, 4'b0101, 1'b0);
    for (int k = 1; k <= 10; k++) begin
      c = 16'(k % 5);
      add(1'b0, 2'b00, 2'd0, 16'd0, c, 16'd4, (c < 16'd2) ? 4'b0101 : 4'b0100, (c == 16'd0));
    end
    row = 0;
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      wr_en = s.wr; wr_sel = s.sel; wr_ch = s.ch; d = s.d;
      step();
      wr_en = 1'b0;
      e = exp_q.pop_front();
      n_cmp++;
      if ({cnt, top, pwm_out, period_end} !== {e.cnt, e.top, e.pwm, e.pe}) begin
        n_bad++;
        $display("FAIL preload_edge row %0d: got cnt=%0d top=%0d pwm=%b pe=%b, want cnt=%0d top=%0d pwm=%b pe=%b",
                 row, cnt, top, pwm_out, period_end, e.cnt, e.top, e.pwm, e.pe);
      end
      row++;
    end
  endtask

  // Compare shadow write mid-period, and another on the boundary cycle
  task automatic test_edge_shadow();
    stim_t s;
    exp_t  e;
    int    row;
    wr(2'b00, 2'd0, 16'h0000);
    wr(2'b11, 2'd0, 16'd0);
    step();
    add(1'b1, 2'b00, 2'd0, 16'h0001, 16'd0, 16'd4, 4'b0101, 1'b0);
    add(1'b0, 2'b00, 2'd0, 16'd0,    16'd1, 16'd4, 4'b0101, 1'b0);
    add(1'b1, 2'b01, 2'd0, 16'd4,    16'd2, 16'd4, 4'b0100, 1'b0);
    add(1'b0, 2'b00, 2'd0, 16'd0,    16'd3, 16'd4, 4'b0100, 1'b0);
    add(1'b0, 2'b00, 2'd0, 16'd0,    16'd4, 16'd4, 4'b0100, 1'b0);
    add(1'b0, 2'b00, 2'd0, 16'd0,    16'd0, 16'd4, 4'b0101, 1'b1);
    add(1'b0, 2'b00, 2'd0, 16'd0,    16'd1, 16'd4, 4'b0101, 1'b0);
    add(1'b0, 2'b00, 2'd0, 16'd0,    16'd2, 16'd4, 4'b0101, 1'b0);
    add(1'b0, 2'b00, 2'd0, 16'd0,    16'd3, 16'd4, 4'b0101, 1'b0);
    add(1'b0, 2'b00, 2'd0, 16'd0,    16'd4, 16'd4, 4'b0100, 1'b0);
    add(1'b1, 2'b01, 2'd0, 16'd1,    16'd0, 16'd4, 4'b0101, 1'b1);
    add(1'b0, 2'b00, 2'd0, 16'd0,    16'd1, 16'd4, 4'b0101, 1'b0);
    add(1'b0, 2'b00, 2'd0, 16'd0,    16'd2, 16'd4, 4'b0101, 1'b0);
    add(1'b0, 2'b00, 2'd0, 16'd0,    16'd3, 16'd4, 4'b0101, 1'b0);
    add(1'b0, 2'b00, 2'd0, 16'd0,    16'd4, 16'd4, 4'b0100, 1'b0);
    add(1'b0, 2'b00, 2'd0, 16'd0,    16'd0, 16'd4, 4'b0101, 1'b1);
    add(1'b0, 2'b00, 2'd0, 16'd0,    16'd1, 16'd4, 4'b0100, 1'b0);
    row = 0;
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      wr_en = s.wr; wr_sel = s.sel; wr_ch = s.ch; d = s.d;
      step();
      wr_en = 1'b0;
      e = exp_q.pop_front();
      n_cmp++;
      if ({cnt, top, pwm_out, period_end} !== {e.cnt, e.top, e.pwm, e.pe}) begin
        n_bad++;
        $display("FAIL edge_shadow row %0d: got cnt=%0d top=%0d pwm=%b pe=%b, want cnt=%0d top=%0d pwm=%b pe=%b",
                 row, cnt, top, pwm_out, period_end, e.cnt, e.top, e.pwm, e.pe);
      end
      row++;
    end
  endtask

  // Centre-aligned counting, TOP=4, cmp0=2: period of 8 cycles
  task automatic test_centre();
    stim_t s;
    exp_t  e;
    int    row;
    logic [15:0] seq [16];
    seq = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd3, 16'd2, 16'd1, 16'd0,
            16'd1, 16'd2, 16'd3, 16'd4, 16'd3, 16'd2, 16'd1, 16'd0};
    wr(2'b00, 2'd0, 16'h0000);
    wr(2'b11, 2'd0, 16'd0);
    wr(2'b01, 2'd0, 16'd2);
    step();
    add(1'b1, 2'b00, 2'd0, 16'h0003, 16'd0, 16'd4, 4'b0101, 1'b0);
    for (int k = 0; k < 16; k++) begin
      add(1'b0, 2'b00, 2'd0, 16'd0, seq[k], 16'd4,
          (seq[k] < 16'd2) ? 4'b0101 : 4'b0100, (seq[k] == 16'd0));
    end
    row = 0;
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      wr_en = s.wr; wr_sel = s.sel; wr_ch = s.ch; d = s.d;
      step();
      wr_en = 1'b0;
      e = exp_q.pop_front();
      n_cmp++;
      if ({cnt, top, pwm_out, period_end} !== {e.cnt, e.top, e.pwm, e.pe}) begin
        n_bad++;
        $display("FAIL centre row %0d: got cnt=%0d top=%0d pwm=%b pe=%b, want cnt=%0d top=%0d pwm=%b pe=%b",
                 row, cnt, top, pwm_out, period_end, e.cnt, e.top, e.pwm, e.pe);
      end
      row++;
    end
  endtask

  // Direct counter write on what would be the boundary edge: no transfer, then wrap
  task automatic test_counter_write();
    stim_t s;
    exp_t  e;
    int    row;
    wr(2'b00, 2'd0, 16'h0000);
    wr(2'b11, 2'd0, 16'd0);
    add(1'b1, 2'b00, 2'd0, 16'h0001, 16'd0, 16'd4, 4'b0101, 1'b0);
    add(1'b1, 2'b10, 2'd0, 16'd6,    16'd1, 16'd4, 4'b0101, 1'b0);
    add(1'b0, 2'b00, 2'd0, 16'd0,    16'd2, 16'd4, 4'b0100, 1'b0);
    add(1'b0, 2'b00, 2'd0, 16'd0,    16'd3, 16'd4, 4'b0100, 1'b0);
    add(1'b0, 2'b00, 2'd0, 16'd0,    16'd4, 16'd4, 4'b0100, 1'b0);
    add(1'b1, 2'b11, 2'd0, 16'd9,    16'd9, 16'd4, 4'b0000, 1'b0);
    add(1'b0, 2'b00, 2'd0, 16'd0,    16'd0, 16'd6, 4'b0101, 1'b1);
    add(1'b0, 2'b00, 2'd0, 16'd0,    16'd1, 16'd6, 4'b0101, 1'b0);
    row = 0;
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      wr_en = s.wr; wr_sel = s.sel; wr_ch = s.ch; d = s.d;
      step();
      wr_en = 1'b0;
      e = exp_q.pop_front();
      n_cmp++;
      if ({cnt, top, pwm_out, period_end} !== {e.cnt, e.top, e.pwm, e.pe}) begin
        n_bad++;
        $display("FAIL counter_write row %0d: got cnt=%0d top=%0d pwm=%b pe=%b, want cnt=%0d top=%0d pwm=%b pe=%b",
                 row, cnt, top, pwm_out, period_end, e.cnt, e.top, e.pwm, e.pe);
      end
      row++;
    end
  endtask

  // Reset asserted between clock edges while running
  task automatic test_async_reset();
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({cnt, top, pwm_out, period_end} !== 37'd0) begin
      n_bad++;
      $display("FAIL async_reset: cnt=%0d top=%0d pwm=%b pe=%b, want all 0", cnt, top, pwm_out, period_end);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      n_cmp++;
      if ({cnt, top, pwm_out, period_end} !== 37'd0) begin
        n_bad++;
        $display("FAIL post_reset cycle %0d: cnt=%0d top=%0d pwm=%b pe=%b, want all 0",
                 k, cnt, top, pwm_out, period_end);
      end
    end
  endtask

  // TOP=0: every cycle is a boundary; cmp above TOP gives a constant high
  task automatic test_top_zero();
    stim_t s;
    exp_t  e;
    int    row;
    wr(2'b01, 2'd0, 16'd1);
    step();
    add(1'b1, 2'b00, 2'd0, 16'h0001, 16'd0, 16'd0, 4'b0001, 1'b0);
    add(1'b0, 2'b00, 2'd0, 16'd0,    16'd0, 16'd0, 4'b0001, 1'b1);
    add(1'b0, 2'b00, 2'd0, 16'd0,    16'd0, 16'd0, 4'b0001, 1'b1);
    add(1'b1, 2'b00, 2'd0, 16'h0003, 16'd0, 16'd0, 4'b0001, 1'b1);
    add(1'b0, 2'b00, 2'd0, 16'd0,    16'd0, 16'd0, 4'b0001, 1'b1);
    row = 0;
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      wr_en = s.wr; wr_sel = s.sel; wr_ch = s.ch; d = s.d;
      step();
      wr_en = 1'b0;
      e = exp_q.pop_front();
      n_cmp++;
      if ({cnt, top, pwm_out, period_end} !== {e.cnt, e.top, e.pwm, e.pe}) begin
        n_bad++;
        $display("FAIL top_zero row %0d: got cnt=%0d top=%0d pwm=%b pe=%b, want cnt=%0d top=%0d pwm=%b pe=%b",
                 row, cnt, top, pwm_out, period_end, e.cnt, e.top, e.pwm, e.pe);
      end
      row++;
    end
  endtask

`ifdef PWM_POLARITY_EN
  // Inverted channel 0, then disabled with the inversion kept
  task automatic test_polarity();
    stim_t s;
    exp_t  e;
    int    row;
    wr(2'b00, 2'd0, 16'h0000);
    wr(2'b11, 2'd0, 16'd0);
    wr(2'b10, 2'd0, 16'd4);
    wr(2'b01, 2'd0, 16'd2);
    step();
    add(1'b1, 2'b00, 2'd0, 16'h0005, 16'd0, 16'd4, 4'b0000, 1'b0);
    add(1'b0, 2'b00, 2'd0, 16'd0,    16'd1, 16'd4, 4'b0000, 1'b0);
    add(1'b0, 2'b00, 2'd0, 16'd0,    16'd2, 16'd4, 4'b0001, 1'b0);
    add(1'b1, 2'b00, 2'd0, 16'h0004, 16'd3, 16'd4, 4'b0001, 1'b0);
    add(1'b0, 2'b00, 2'd0, 16'd0,    16'd3, 16'd4, 4'b0001, 1'b0);
    row = 0;
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      wr_en = s.wr; wr_sel = s.sel; wr_ch = s.ch; d = s.d;
      step();
      wr_en = 1'b0;
      e = exp_q.pop_front();
      n_cmp++;
      if ({cnt, top, pwm_out, period_end} !== {e.cnt, e.top, e.pwm, e.pe}) begin
        n_bad++;
        $display("FAIL polarity row %0d: got cnt=%0d top=%0d pwm=%b pe=%b, want cnt=%0d top=%0d pwm=%b pe=%b",
                 row, cnt, top, pwm_out, period_end, e.cnt, e.top, e.pwm, e.pe);
      end
      row++;
    end
  endtask
`endif

  initial begin
    rst_n  = 1'b0;
    wr_en  = 1'b0;
    wr_sel = 2'b00;
    wr_ch  = 2'd0;
    d      = 16'd0;
    test_reset();
    test_preload_edge();
    test_edge_shadow();
    test_centre();
    test_counter_write();
    test_async_reset();
    test_top_zero();
`ifdef PWM_POLARITY_EN
    test_polarity();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
